mddr_port_arbiter: RTL and testbench
====================================

// Module: mddr_port_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single mDDR controller (bemicro_soc mddr_ctrl) between NUM_PORTS bursting requesters.
//  Sequences one burst at a time: grant, command issue, per-beat write/read data, then release.
//  Watchdog aborts stalled bursts. Sits inside the SoC between requester bridges (CPU I/D, DMA) and the controller command port.
// PARAMETERS
//  NUM_PORTS  3     number of requesters (2..8)
//  ADDR_W     25    byte address width (32 MB mDDR)
//  BURST_W    4     burst length field width; beats = burst+1 (1..16)
//  TIMEOUT    1023  max idle cycles between beats before abort
// PORTS
//  clk_clk          in   1              system clock
//  reset_reset_n    in   1              async active-low reset
//  port_req         in   NUM_PORTS      request, held until last ack
//  port_we          in   NUM_PORTS      1=write burst
//  port_addr        in   NUM_PORTS*ADDR_W   start address, packed by port
//  port_burst       in   NUM_PORTS*BURST_W  beats-1
//  port_wdata       in   NUM_PORTS*32   write beat data
//  port_sel         in   NUM_PORTS*4    write byte enables
//  port_ack         out  NUM_PORTS      beat accepted (wr) / data valid (rd)
//  port_err         out  NUM_PORTS      1-cycle pulse: burst aborted by watchdog
//  port_rdata       out  32             read data, shared, valid with port_ack
//  mem_cmd_valid    out  1              command to controller
//  mem_cmd_ready    in   1              controller accepts command
//  mem_cmd_we       out  1              command direction
//  mem_cmd_addr     out  ADDR_W         command address
//  mem_cmd_burst    out  BURST_W        command beats-1
//  mem_wdata        out  32             write beat data
//  mem_wsel         out  4              write byte enables
//  mem_wdata_ready  in   1              controller consumes write beat
//  mem_rdata        in   32             read beat data
//  mem_rdata_valid  in   1              read beat present
//  mem_abort        out  1              1-cycle pulse: drop current burst
// BEHAVIOUR
//  - Reset: state IDLE, grant=0, last_grant=NUM_PORTS-1, beat_cnt=0, wdog=0; all outputs 0.
//  - States: IDLE -> CMD -> (WR|RD) -> IDLE.
//  - IDLE: if any port_req, pick first requester at or after last_grant+1 (mod NUM_PORTS); register grant, we, addr, burst; go CMD. Latency: req at cycle N -> mem_cmd_valid at N+1.
//  - CMD: mem_cmd_valid=1, fields stable until mem_cmd_ready; on accept go WR/RD, beat_cnt=0, wdog=0.
//  - WR: mem_wdata/mem_wsel = granted port's live wdata/sel; port_ack[g]=mem_wdata_ready (combinational).
//  - RD: port_rdata=mem_rdata, port_ack[g]=mem_rdata_valid.
//  - Each beat increments beat_cnt; beat with beat_cnt==burst is last -> IDLE, last_grant<=g. One idle turnaround cycle between bursts; no back-to-back commands.
//  - Requester drops port_req mid-burst: burst still completes on memory side; remaining writes use mem_wsel=4'h0; remaining read beats discarded (port_ack stays 0).
//  - Watchdog: in WR/RD, wdog counts cycles without a beat, clears on a beat; on wdog==TIMEOUT: mem_abort=1, port_err[g]=1 for one cycle, -> IDLE, last_grant<=g.
//  - Arbitration is evaluated only in IDLE; requests arriving mid-burst wait. Single requester re-wins after turnaround if no other req.
//  - Async reset mid-burst: all state cleared immediately; no mem_abort emitted (controller is reset by the same net).
//  - port_ack/port_err only ever asserted for the granted port; at most one bit set.
// STRUCTURE
//  - mddr_arb_pkg: state encoding (IDLE, CMD, WR, RD), TIMEOUT width function, default widths.
//  - Sub-module rr_pick: combinational round-robin priority encoder (req vector, last_grant -> grant index, any).
//  - Top holds FSM, registered command fields, beat counter, watchdog, data muxes.
// TESTING
//  - Single write: port0 req we=1 addr=0x100 burst=3, cmd_ready after 2 cycles, wdata_ready every cycle -> 4 acks, mem_wdata matches port0 beats, back to IDLE.
//  - Round-robin: ports 0,1,2 request continuously, burst=0 -> grant order 0,1,2,0,1,2; each grant 1 idle cycle apart.
//  - Read burst: port2 burst=7, rdata_valid gapped (1 on/1 off) -> 8 acks, port_rdata equals mem_rdata on each ack.
//  - Watchdog: TIMEOUT=15, read burst=3, rdata_valid stops after beat 1 -> mem_abort and port_err[g] pulse on 16th idle cycle; next requester granted.
//  - Drop mid-write: port1 burst=3 drops req after beat 1 -> beats 2,3 sent with mem_wsel=0, port_ack[1]=0 for them.
//  - Reset mid-burst: deassert reset_reset_n during WR -> all outputs 0 asynchronously; after release, first grant goes to port0.

Source files
------------

// File: rtl/mddr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mddr_arb_pkg
// Description : Shared types, default widths and sizing helpers for the
//               mDDR port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mddr_arb_pkg;

    // Burst sequencing states: grant -> command -> data beats -> release.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_NUM_PORTS = 3;
    localparam int unsigned DEF_ADDR_W    = 25;
    localparam int unsigned DEF_BURST_W   = 4;
    localparam int unsigned DEF_TIMEOUT   = 1023;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned SEL_W         = 4;

    // Bits needed to hold a port index; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed for a counter that must reach max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority encoder. Returns the first
//               requester at or after last_grant+1 (wrapping) and whether any
//               request is present at all.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mddr_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic [IDX_W-1:0]     grant_o,
    output logic                 any_o
);

    logic [IDX_W-1:0] cand;

    // Walk the ports starting just after the previous winner; first hit wins.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = IDX_W'((32'(last_grant_i) + i) % NUM_PORTS);
            if (!any_o && req_i[cand]) begin
                grant_o = cand;
                any_o   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mddr_port_arbiter
// Description : Round-robin arbiter sharing the mDDR controller between
//               bursting requesters. One burst at a time: grant, command,
//               per-beat data, release. A watchdog aborts stalled bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module mddr_port_arbiter
    import mddr_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned BURST_W   = DEF_BURST_W,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset_n,
    input  logic [NUM_PORTS-1:0]           port_req,
    input  logic [NUM_PORTS-1:0]           port_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]    port_addr,
    input  logic [NUM_PORTS*BURST_W-1:0]   port_burst,
    input  logic [NUM_PORTS*DATA_W-1:0]    port_wdata,
    input  logic [NUM_PORTS*SEL_W-1:0]     port_sel,
    output logic [NUM_PORTS-1:0]           port_ack,
    output logic [NUM_PORTS-1:0]           port_err,
    output logic [DATA_W-1:0]              port_rdata,
    output logic                           mem_cmd_valid,
    input  logic                           mem_cmd_ready,
    output logic                           mem_cmd_we,
    output logic [ADDR_W-1:0]              mem_cmd_addr,
    output logic [BURST_W-1:0]             mem_cmd_burst,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic [SEL_W-1:0]               mem_wsel,
    input  logic                           mem_wdata_ready,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_rdata_valid,
    output logic                           mem_abort
);

    localparam int unsigned       IDX_W    = idx_width(NUM_PORTS);
    localparam int unsigned       WDOG_W   = cnt_width(TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_PORTS - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] beat_cnt_q;
    logic [WDOG_W-1:0]  wdog_q;
    logic               dropped_q;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               pick_we;
    logic [ADDR_W-1:0]  pick_addr;
    logic [BURST_W-1:0] pick_burst;

    logic               gnt_req;
    logic [DATA_W-1:0]  gnt_wdata;
    logic [SEL_W-1:0]   gnt_sel;

    logic               in_wr;
    logic               in_rd;
    logic               beat;
    logic               last_beat;
    logic               timeout;
    logic               live;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req_i        (port_req),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_idx),
        .any_o        (pick_any)
    );

    // Command fields of the arbitration winner, captured when leaving IDLE.
    always_comb begin
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_burst = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_we    = port_we[i];
                pick_addr  = port_addr[i*ADDR_W +: ADDR_W];
                pick_burst = port_burst[i*BURST_W +: BURST_W];
            end
        end
    end

    // Live request and write data of the port that currently owns the bus.
    always_comb begin
        gnt_req   = 1'b0;
        gnt_wdata = '0;
        gnt_sel   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                gnt_req   = port_req[i];
                gnt_wdata = port_wdata[i*DATA_W +: DATA_W];
                gnt_sel   = port_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    assign in_wr     = (state_q == ST_WR);
    assign in_rd     = (state_q == ST_RD);
    assign beat      = (in_wr && mem_wdata_ready) || (in_rd && mem_rdata_valid);
    assign last_beat = beat && (beat_cnt_q == burst_q);
    // A beat landing on the deadline cycle still counts; only true silence aborts.
    assign timeout   = (in_wr || in_rd) && !beat && (wdog_q == WDOG_MAX);
    // Once the owner lets go of its request, the rest of the burst is orphaned.
    assign live      = gnt_req && !dropped_q;

    assign mem_cmd_valid = (state_q == ST_CMD);
    assign mem_cmd_we    = we_q;
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_burst = burst_q;
    assign mem_wdata     = in_wr ? gnt_wdata : '0;
    // Orphaned write beats still complete on the memory side but write nothing.
    assign mem_wsel      = (in_wr && live) ? gnt_sel : '0;
    assign port_rdata    = in_rd ? mem_rdata : '0;
    assign mem_abort     = timeout;

    // Per-port handshake: only the owner ever sees ack or err.
    always_comb begin
        port_ack = '0;
        port_err = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            port_ack[i] = beat && live && (grant_q == IDX_W'(i));
            port_err[i] = timeout && (grant_q == IDX_W'(i));
        end
    end

    // Burst sequencer: arbitration, command handshake, beat count, watchdog.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            we_q         <= 1'b0;
            addr_q       <= '0;
            burst_q      <= '0;
            beat_cnt_q   <= '0;
            wdog_q       <= '0;
            dropped_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q   <= pick_idx;
                        we_q      <= pick_we;
                        addr_q    <= pick_addr;
                        burst_q   <= pick_burst;
                        dropped_q <= 1'b0;
                        state_q   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!gnt_req) begin
                        dropped_q <= 1'b1;
                    end
                    if (mem_cmd_ready) begin
                        state_q    <= we_q ? ST_WR : ST_RD;
                        beat_cnt_q <= '0;
                        wdog_q     <= '0;
                    end
                end
                ST_WR, ST_RD: begin
                    if (!gnt_req) begin
                        dropped_q <= 1'b1;
                    end
                    if (timeout) begin
                        state_q      <= ST_IDLE;
                        last_grant_q <= grant_q;
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        wdog_q     <= '0;
                        if (last_beat) begin
                            state_q      <= ST_IDLE;
                            last_grant_q <= grant_q;
                        end
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mddr_port_arbiter
// Description : Self-checking bench for mddr_port_arbiter: directed scenarios
//               plus a randomized multi-port run against a transaction-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mddr_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 25;
    localparam int BW = 4;
    localparam int TO = 15;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic [NP-1:0]     port_req;
    logic [NP-1:0]     port_we;
    logic [NP*AW-1:0]  port_addr;
    logic [NP*BW-1:0]  port_burst;
    logic [NP*32-1:0]  port_wdata;
    logic [NP*4-1:0]   port_sel;
    logic [NP-1:0]     port_ack;
    logic [NP-1:0]     port_err;
    logic [31:0]       port_rdata;
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_we;
    logic [AW-1:0]     mem_cmd_addr;
    logic [BW-1:0]     mem_cmd_burst;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wsel;
    logic              mem_wdata_ready;
    logic [31:0]       mem_rdata;
    logic              mem_rdata_valid;
    logic              mem_abort;

    int checks = 0;
    int errors = 0;

    mddr_port_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .BURST_W   (BW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .port_req        (port_req),
        .port_we         (port_we),
        .port_addr       (port_addr),
        .port_burst      (port_burst),
        .port_wdata      (port_wdata),
        .port_sel        (port_sel),
        .port_ack        (port_ack),
        .port_err        (port_err),
        .port_rdata      (port_rdata),
        .mem_cmd_valid   (mem_cmd_valid),
        .mem_cmd_ready   (mem_cmd_ready),
        .mem_cmd_we      (mem_cmd_we),
        .mem_cmd_addr    (mem_cmd_addr),
        .mem_cmd_burst   (mem_cmd_burst),
        .mem_wdata       (mem_wdata),
        .mem_wsel        (mem_wsel),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_abort       (mem_abort)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic clear_inputs();
        port_req = '0; port_we = '0; port_addr = '0; port_burst = '0;
        port_wdata = '0; port_sel = '0; mem_cmd_ready = 1'b0;
        mem_wdata_ready = 1'b0; mem_rdata = '0; mem_rdata_valid = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
    endtask

    task automatic set_port(input int p, input logic we, input logic [AW-1:0] addr,
                            input logic [BW-1:0] bl, input logic [31:0] wd, input logic [3:0] sel);
        port_we[p] = we;
        port_addr[p*AW +: AW] = addr;
        port_burst[p*BW +: BW] = bl;
        port_wdata[p*32 +: 32] = wd;
        port_sel[p*4 +: 4] = sel;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_reset_n = 1'b0;
        port_req = '1; port_we = '1; mem_cmd_ready = 1'b1; mem_wdata_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF; mem_rdata_valid = 1'b1;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        checks++;
        if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_burst, mem_abort} !== '0) begin
            errors++;
            $display("FAIL reset_cmd: got valid=%b we=%b addr=%h burst=%h abort=%b expected all 0",
                     mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_burst, mem_abort);
        end
        checks++;
        if ({mem_wdata, mem_wsel, port_ack, port_err, port_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got wdata=%h wsel=%h ack=%b err=%b rdata=%h expected all 0",
                     mem_wdata, mem_wsel, port_ack, port_err, port_rdata);
        end
        @(posedge clk_clk); #1;
        clear_inputs();
        reset_reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        apply_reset();
        set_port(0, 1'b1, 25'h100, 4'd3, 32'hA000_0000, 4'h1);
        port_req = 3'b001;
        @(negedge clk_clk);
        checks++;
        if (mem_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL wr_idle_cycle: got cmd_valid=%b expected 0", mem_cmd_valid);
        end
        step();
        for (int c = 0; c < 3; c++) begin
            mem_cmd_ready = (c == 2);
            @(negedge clk_clk);
            checks++;
            if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_burst} !== {1'b1, 1'b1, 25'h100, 4'd3}) begin
                errors++;
                $display("FAIL wr_cmd: cycle %0d got valid=%b we=%b addr=%h burst=%0d expected 1 1 100 3",
                         c, mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_burst);
            end
            step();
        end
        mem_cmd_ready = 1'b0;
        mem_wdata_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            port_wdata[31:0] = 32'hA000_0000 + 32'(b);
            port_sel[3:0] = 4'(b + 1);
            @(negedge clk_clk);
            checks++;
            if (port_ack !== 3'b001 || mem_wdata !== 32'hA000_0000 + 32'(b) || mem_wsel !== 4'(b + 1)) begin
                errors++;
                $display("FAIL wr_beat: beat %0d got ack=%b wdata=%h wsel=%h expected 001 %h %h",
                         b, port_ack, mem_wdata, mem_wsel, 32'hA000_0000 + 32'(b), 4'(b + 1));
            end
            step();
        end
        port_req = '0;
        mem_wdata_ready = 1'b0;
        @(negedge clk_clk);
        checks++;
        if (mem_cmd_valid !== 1'b0 || port_ack !== 3'b000) begin
            errors++; $display("FAIL wr_release: got cmd_valid=%b ack=%b expected 0 000", mem_cmd_valid, port_ack);
        end
        step();
    endtask

    task automatic test_round_robin();
        int order[$];
        int ack_cyc[$];
        apply_reset();
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(p * 64), '0, 32'(p), 4'hF);
        port_req = 3'b111;
        mem_cmd_ready = 1'b1;
        mem_wdata_ready = 1'b1;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            @(negedge clk_clk);
            if (port_ack !== 3'b000) begin
                order.push_back($clog2(port_ack));
                ack_cyc.push_back(c);
            end
            step();
        end
        clear_inputs();
        checks++;
        if (order.size() != 6) begin
            errors++; $display("FAIL rr_count: got %0d grants expected 6", order.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (order[i] != i % NP) begin
                    errors++; $display("FAIL rr_order: grant %0d got port %0d expected %0d", i, order[i], i % NP);
                end
            end
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (ack_cyc[i] - ack_cyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL rr_spacing: grant %0d got %0d cycles expected 3", i, ack_cyc[i] - ack_cyc[i-1]);
                end
            end
        end
        step();
    endtask

    task automatic test_read_burst();
        int acks = 0;
        apply_reset();
        set_port(2, 1'b0, 25'h1234, 4'd7, 32'h0, 4'h0);
        port_req = 3'b100;
        mem_cmd_ready = 1'b1;
        step();
        @(negedge clk_clk);
        checks++;
        if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_burst} !== {1'b1, 1'b0, 25'h1234, 4'd7}) begin
            errors++;
            $display("FAIL rd_cmd: got valid=%b we=%b addr=%h burst=%0d expected 1 0 1234 7",
                     mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_burst);
        end
        step();
        mem_cmd_ready = 1'b0;
        for (int c = 0; c < 40 && acks < 8; c++) begin
            mem_rdata_valid = (c % 2 == 0);
            mem_rdata = $urandom;
            @(negedge clk_clk);
            checks++;
            if (mem_rdata_valid) begin
                if (port_ack !== 3'b100 || port_rdata !== mem_rdata) begin
                    errors++;
                    $display("FAIL rd_beat: beat %0d got ack=%b rdata=%h expected 100 %h", acks, port_ack, port_rdata, mem_rdata);
                end
                acks++;
            end else if (port_ack !== 3'b000) begin
                errors++; $display("FAIL rd_gap: got ack=%b expected 000", port_ack);
            end
            step();
        end
        clear_inputs();
        @(negedge clk_clk);
        checks++;
        if (acks != 8 || mem_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_done: got acks=%0d cmd_valid=%b expected 8 0", acks, mem_cmd_valid);
        end
        step();
    endtask

    task automatic test_watchdog();
        apply_reset();
        set_port(0, 1'b0, 25'h0777, 4'd3, 32'h0, 4'h0);
        set_port(1, 1'b1, 25'h0999, 4'd0, 32'h1, 4'hF);
        port_req = 3'b011;
        mem_cmd_ready = 1'b1;
        step();
        step();
        mem_cmd_ready = 1'b0;
        mem_rdata_valid = 1'b1;
        step();
        step();
        mem_rdata_valid = 1'b0;
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clk_clk);
            checks++;
            if (k <= TO) begin
                if (mem_abort !== 1'b0 || port_err !== 3'b000) begin
                    errors++; $display("FAIL wdog_early: idle %0d got abort=%b err=%b expected 0 000", k, mem_abort, port_err);
                end
            end else if (mem_abort !== 1'b1 || port_err !== 3'b001 || port_ack !== 3'b000) begin
                errors++;
                $display("FAIL wdog_fire: idle %0d got abort=%b err=%b ack=%b expected 1 001 000", k, mem_abort, port_err, port_ack);
            end
            step();
        end
        port_req = 3'b010;
        @(negedge clk_clk);
        checks++;
        if (mem_abort !== 1'b0 || port_err !== 3'b000 || mem_cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL wdog_pulse: got abort=%b err=%b cmd_valid=%b expected 0 000 0", mem_abort, port_err, mem_cmd_valid);
        end
        step();
        @(negedge clk_clk);
        checks++;
        if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 25'h0999 || mem_cmd_we !== 1'b1) begin
            errors++;
            $display("FAIL wdog_next: got valid=%b addr=%h we=%b expected 1 0999 1", mem_cmd_valid, mem_cmd_addr, mem_cmd_we);
        end
        step();
    endtask

    task automatic test_drop_write();
        apply_reset();
        set_port(1, 1'b1, 25'h0200, 4'd3, 32'hCAFE_0000, 4'hC);
        port_req = 3'b010;
        mem_cmd_ready = 1'b1;
        step();
        step();
        mem_cmd_ready = 1'b0;
        mem_wdata_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) port_req[1] = 1'b0;
            @(negedge clk_clk);
            checks++;
            if (b < 2) begin
                if (port_ack !== 3'b010 || mem_wsel !== 4'hC) begin
                    errors++; $display("FAIL drop_live: beat %0d got ack=%b wsel=%h expected 010 c", b, port_ack, mem_wsel);
                end
            end else if (port_ack !== 3'b000 || mem_wsel !== 4'h0) begin
                errors++; $display("FAIL drop_orphan: beat %0d got ack=%b wsel=%h expected 000 0", b, port_ack, mem_wsel);
            end
            step();
        end
        mem_wdata_ready = 1'b0;
        set_port(0, 1'b1, 25'h0AAA, 4'd0, 32'h0, 4'hF);
        port_req = 3'b001;
        @(negedge clk_clk);
        checks++;
        if (mem_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL drop_turnaround: got cmd_valid=%b expected 0", mem_cmd_valid);
        end
        step();
        @(negedge clk_clk);
        checks++;
        if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 25'h0AAA) begin
            errors++; $display("FAIL drop_next: got valid=%b addr=%h expected 1 0aaa", mem_cmd_valid, mem_cmd_addr);
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        set_port(0, 1'b1, 25'h0ABCDE, 4'd7, 32'h5555_0000, 4'hF);
        set_port(1, 1'b1, 25'h001234, 4'd0, 32'h1, 4'h3);
        port_req = 3'b001;
        mem_cmd_ready = 1'b1;
        mem_wdata_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        mem_rdata_valid = 1'b1;
        step();
        step();
        @(negedge clk_clk);
        checks++;
        if (port_ack !== 3'b001) begin
            errors++; $display("FAIL rstmid_inwr: got ack=%b expected 001", port_ack);
        end
        @(posedge clk_clk);
        #2 reset_reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_burst, mem_wdata, mem_wsel,
             mem_abort, port_ack, port_err, port_rdata} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got valid=%b addr=%h wdata=%h wsel=%h abort=%b ack=%b err=%b rdata=%h expected all 0",
                     mem_cmd_valid, mem_cmd_addr, mem_wdata, mem_wsel, mem_abort, port_ack, port_err, port_rdata);
        end
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b1;
        port_req = 3'b011;
        mem_rdata_valid = 1'b0;
        mem_wdata_ready = 1'b0;
        step();
        @(negedge clk_clk);
        checks++;
        if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 25'h0ABCDE) begin
            errors++; $display("FAIL rstmid_first_grant: got valid=%b addr=%h expected 1 0abcde", mem_cmd_valid, mem_cmd_addr);
        end
        step();
    endtask

    // Several ports each issue a queue of random bursts while the memory side
    // throttles randomly; the model tracks which port should own the bus.
    task automatic test_random();
        int          nb [NP];
        int          bi [NP];
        bit          need_new [NP];
        logic        we_r [NP];
        logic [AW-1:0] ad [NP];
        logic [BW-1:0] bl [NP];
        logic [31:0] base [NP];
        logic [3:0]  sl [NP];
        logic [NP-1:0] exp_ack;
        int  last_g = NP - 1;
        int  phase = 0;
        int  cur = 0;
        int  beats_done = 0;
        int  gap = 0;
        int  total = 0;
        int  bursts_done = 0;
        bit  all_done = 1'b0;
        bit  found;
        logic bt;
        apply_reset();
        for (int p = 0; p < NP; p++) begin
            nb[p] = 3 + $urandom_range(0, 2);
            total += nb[p];
            need_new[p] = 1'b1;
            bi[p] = 0;
        end
        for (int cyc = 0; cyc < 5000; cyc++) begin
            all_done = (phase == 0);
            for (int p = 0; p < NP; p++) if (nb[p] > 0) all_done = 1'b0;
            if (all_done) break;
            for (int p = 0; p < NP; p++) begin
                if (need_new[p] && nb[p] > 0) begin
                    we_r[p] = 1'($urandom);
                    ad[p]   = AW'($urandom);
                    bl[p]   = BW'($urandom_range(0, 15));
                    base[p] = $urandom;
                    sl[p]   = 4'($urandom);
                    bi[p]   = 0;
                    need_new[p] = 1'b0;
                end
                port_req[p] = (nb[p] > 0);
                set_port(p, we_r[p], ad[p], bl[p], base[p] + 32'(bi[p]), sl[p]);
            end
            mem_cmd_ready   = 1'($urandom);
            mem_wdata_ready = (gap >= 4) ? 1'b1 : 1'($urandom);
            mem_rdata_valid = (gap >= 4) ? 1'b1 : 1'($urandom);
            mem_rdata       = $urandom;
            @(negedge clk_clk);
            if (phase == 0) begin
                checks++;
                if (mem_cmd_valid !== 1'b0 || port_ack !== '0) begin
                    errors++; $display("FAIL rnd_idle: got cmd_valid=%b ack=%b expected 0 000", mem_cmd_valid, port_ack);
                end
                if (port_req != '0) begin
                    found = 1'b0;
                    for (int i = 1; i <= NP; i++) begin
                        if (!found && port_req[(last_g + i) % NP]) begin
                            cur = (last_g + i) % NP;
                            found = 1'b1;
                        end
                    end
                    phase = 1;
                end
            end else if (phase == 1) begin
                checks++;
                if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_burst} !== {1'b1, we_r[cur], ad[cur], bl[cur]}) begin
                    errors++;
                    $display("FAIL rnd_cmd: port %0d got valid=%b we=%b addr=%h burst=%0d expected 1 %b %h %0d",
                             cur, mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_burst, we_r[cur], ad[cur], bl[cur]);
                end
                if (mem_cmd_ready) begin
                    phase = 2;
                    beats_done = 0;
                    gap = 0;
                end
            end else begin
                bt = we_r[cur] ? mem_wdata_ready : mem_rdata_valid;
                exp_ack = bt ? (NP'(1) << cur) : '0;
                checks++;
                if (port_ack !== exp_ack || mem_abort !== 1'b0 || port_err !== '0) begin
                    errors++;
                    $display("FAIL rnd_ack: port %0d got ack=%b abort=%b err=%b expected %b 0 000",
                             cur, port_ack, mem_abort, port_err, exp_ack);
                end
                if (bt) begin
                    checks++;
                    if (we_r[cur]) begin
                        if (mem_wdata !== base[cur] + 32'(bi[cur]) || mem_wsel !== sl[cur]) begin
                            errors++;
                            $display("FAIL rnd_wdata: port %0d beat %0d got %h/%h expected %h/%h",
                                     cur, bi[cur], mem_wdata, mem_wsel, base[cur] + 32'(bi[cur]), sl[cur]);
                        end
                    end else if (port_rdata !== mem_rdata) begin
                        errors++; $display("FAIL rnd_rdata: port %0d got %h expected %h", cur, port_rdata, mem_rdata);
                    end
                    bi[cur]++;
                    beats_done++;
                    gap = 0;
                    if (beats_done == int'(bl[cur]) + 1) begin
                        last_g = cur;
                        phase = 0;
                        nb[cur]--;
                        need_new[cur] = 1'b1;
                        bursts_done++;
                    end
                end else begin
                    gap++;
                end
            end
            step();
        end
        clear_inputs();
        checks++;
        if (bursts_done != total) begin
            errors++; $display("FAIL rnd_complete: got %0d bursts expected %0d", bursts_done, total);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_burst();
        test_watchdog();
        test_drop_write();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
